// File: rtl/msg_char_streamer_pkg.sv
//------------------------------------------------------------------------------
// Module   : msg_char_streamer_pkg
// Purpose  : Shared sizes, label encodings, FSM state encoding and the
//            length-clamp helper for the message character streamer.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package msg_char_streamer_pkg;

  localparam int MESSAGE_LENGTH = 160;  // maximum characters per message
  localparam int CHAR_LENGTH    = 8;    // bits per character
  localparam int LEN_WIDTH      = 8;    // width of length and index fields
  localparam int MSG_WIDTH      = MESSAGE_LENGTH * CHAR_LENGTH;

  // Label encodings carried alongside a message (other codes reserved)
  localparam logic [1:0] LABEL_HAM  = 2'b00;
  localparam logic [1:0] LABEL_SPAM = 2'b01;

  localparam logic [LEN_WIDTH-1:0] c_MAX_LEN = LEN_WIDTH'(MESSAGE_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Requested lengths beyond the buffer size are clamped to the buffer size
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
    return (len > c_MAX_LEN) ? c_MAX_LEN : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msg_char_streamer_if.sv
//------------------------------------------------------------------------------
// Module   : msg_char_streamer_if
// Purpose  : Bundles the parallel message-load handshake, the per-character
//            output stream and the completion/status signals.
// Modports : master - streamer side (accepts loads, drives char stream/done)
//            slave  - environment side (producer and consumer)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface msg_char_streamer_if;
  import msg_char_streamer_pkg::*;

  // Parallel load side
  logic                   load_valid;
  logic                   load_ready;
  logic [MSG_WIDTH-1:0]   load_msg;
  logic [LEN_WIDTH-1:0]   load_length;
  logic [1:0]             load_label;

  // Character stream side
  logic                   char_valid;
  logic                   char_ready;
  logic [CHAR_LENGTH-1:0] char_data;
  logic [LEN_WIDTH-1:0]   char_index;
  logic                   char_first;
  logic                   char_last;
  logic [1:0]             char_label;

  // Completion / status
  logic                   done;
  logic [LEN_WIDTH-1:0]   done_count;
  logic                   busy;

  modport master (
    input  load_valid, load_msg, load_length, load_label, char_ready,
    output load_ready, char_valid, char_data, char_index, char_first,
           char_last, char_label, done, done_count, busy
  );

  modport slave (
    output load_valid, load_msg, load_length, load_label, char_ready,
    input  load_ready, char_valid, char_data, char_index, char_first,
           char_last, char_label, done, done_count, busy
  );

endinterface

`default_nettype wire

// File: rtl/msg_shift_buffer.sv
//------------------------------------------------------------------------------
// Module   : msg_shift_buffer
// Purpose  : Parallel-load message register that shifts left by one character
//            per step; the top character is tapped out directly.
// Ports    : clk, rst_n (async, active-low)
//            i_load  - capture i_data (highest priority)
//            i_clear - zero the buffer
//            i_shift - shift left by CHAR bits, zero fill
//            i_data  - parallel message, char 0 at the MSB end
//            o_top   - top CHAR bits of the buffer
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module msg_shift_buffer #(
  parameter int WIDTH = 1280,
  parameter int CHAR  = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic             i_clear,
  input  wire logic             i_shift,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [CHAR-1:0]  o_top
);

  logic [WIDTH-1:0] r_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_data;
    end else if (i_clear) begin
      r_buf <= '0;
    end else if (i_shift) begin
      r_buf <= {r_buf[WIDTH-CHAR-1:0], {CHAR{1'b0}}};
    end
  end

  assign o_top = r_buf[WIDTH-1 -: CHAR];

endmodule

`default_nettype wire

// File: rtl/msg_char_streamer.sv
//------------------------------------------------------------------------------
// Module   : msg_char_streamer
// Purpose  : Accepts one whole message in parallel and streams it out one
//            character per handshake with index, first/last flags and label,
//            then pulses done with the number of characters emitted.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-low reset
//            bus   - msg_char_streamer_if.master (load, char stream, done,
//                    done_count, busy)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module msg_char_streamer
  import msg_char_streamer_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           reset,
  msg_char_streamer_if.master bus
);

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_load_ready;
  logic                   r_char_valid;
  logic [LEN_WIDTH-1:0]   r_index;
  logic                   r_first;
  logic                   r_last;
  logic [1:0]             r_label;
  logic [LEN_WIDTH-1:0]   r_len;
  logic                   r_done;
  logic [LEN_WIDTH-1:0]   r_done_count;

  logic                   w_load_fire;
  logic                   w_char_fire;
  logic [LEN_WIDTH-1:0]   w_eff_len;
  logic [LEN_WIDTH-1:0]   w_index_inc;
  logic [CHAR_LENGTH-1:0] w_top;

  assign w_load_fire = (r_state == ST_IDLE) && r_load_ready && bus.load_valid;
  assign w_char_fire = (r_state == ST_STREAM) && r_char_valid && bus.char_ready;
  assign w_eff_len   = clamp_len(bus.load_length);
  assign w_index_inc = r_index + LEN_WIDTH'(1);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load_fire) begin
          w_state_nxt = (w_eff_len == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_char_fire && r_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs and per-message bookkeeping. Handshake/status flags
  // are derived from the next state so they line up with the state they
  // describe; load_ready stays low through reset and rises on the first edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_ready <= 1'b0;
      r_char_valid <= 1'b0;
      r_index      <= '0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_label      <= '0;
      r_len        <= '0;
      r_done       <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_load_ready <= (w_state_nxt == ST_IDLE);
      r_char_valid <= (w_state_nxt == ST_STREAM);
      r_done       <= (w_state_nxt == ST_DONE);

      if (w_state_nxt == ST_DONE) begin
        // A zero-length load goes straight to DONE with the fresh length
        r_done_count <= w_load_fire ? w_eff_len : r_len;
      end else begin
        r_done_count <= '0;
      end

      if (w_load_fire) begin
        r_len   <= w_eff_len;
        r_label <= bus.load_label;
        r_index <= '0;
        r_first <= 1'b1;
        r_last  <= (w_eff_len == LEN_WIDTH'(1));
      end else if (w_char_fire && !r_last) begin
        r_index <= w_index_inc;
        r_first <= 1'b0;
        r_last  <= (w_index_inc == (r_len - LEN_WIDTH'(1)));
      end
    end
  end

  // The final beat clears the buffer instead of shifting so char_data
  // returns to zero between messages.
  msg_shift_buffer #(
    .WIDTH (MSG_WIDTH),
    .CHAR  (CHAR_LENGTH)
  ) u_shift_buffer (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_load_fire),
    .i_clear (w_char_fire && r_last),
    .i_shift (w_char_fire && !r_last),
    .i_data  (bus.load_msg),
    .o_top   (w_top)
  );

  assign bus.load_ready = r_load_ready;
  assign bus.char_valid = r_char_valid;
  assign bus.char_data  = w_top;
  assign bus.char_index = r_index;
  assign bus.char_first = r_first;
  assign bus.char_last  = r_last;
  assign bus.char_label = r_label;
  assign bus.done       = r_done;
  assign bus.done_count = r_done_count;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_msg_char_streamer.sv
//------------------------------------------------------------------------------
// Module   : tb_msg_char_streamer
// Purpose  : Self-checking bench for msg_char_streamer: table of directed
//            messages, randomized messages against a reference model, and
//            hand-written reset-abort and back-to-back load sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_msg_char_streamer;
  import msg_char_streamer_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         index;
    logic       first;
    logic       last;
    logic [1:0] label;
  } beat_t;

  typedef struct {
    int         len;
    logic [1:0] label;
    int         ready_mode;  // 0 always ready, 1 pattern 1,0,0, 2 random
    int         fill;        // 0 "hi", 1 byte=i (char 0 is 0x00), 2 random
    int         exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  msg_char_streamer_if bus();

  msg_char_streamer u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    done_q[$];
  logic [7:0] mem [2][MESSAGE_LENGTH];
  int    ready_mode = 0;
  int    cyc_ready  = 0;
  vec_t  vt[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Consumer ready driver
  initial begin
    bus.char_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.char_ready = 1'b1;
        1:       begin bus.char_ready = (cyc_ready % 3 == 0); cyc_ready++; end
        default: bus.char_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: samples 1 ns before each rising edge
  initial begin : monitor
    beat_t prev, cur;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '{8'h00, 0, 1'b0, 1'b0, 2'b00};
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = '{bus.char_data, int'(bus.char_index), bus.char_first, bus.char_last, bus.char_label};
        if (prev_stall) begin
          chk("stall_hold_valid", bus.char_valid, 1);
          chk("stall_hold_data",  cur.data,  prev.data);
          chk("stall_hold_index", cur.index, prev.index);
          chk("stall_hold_last",  cur.last,  prev.last);
        end
        if (bus.char_valid && bus.char_ready) got_q.push_back(cur);
        if (bus.done) begin
          chk("valid_during_done", bus.char_valid, 0);
          done_q.push_back(int'(bus.done_count));
        end
        prev_stall = bus.char_valid && !bus.char_ready;
        prev       = cur;
      end
    end
  end

  function automatic int model_eff(input int len);
    return (len > MESSAGE_LENGTH) ? MESSAGE_LENGTH : len;
  endfunction

  task automatic fill_msg(input int sel, input int mode);
    for (int i = 0; i < MESSAGE_LENGTH; i++) begin
      case (mode)
        0:       mem[sel][i] = (i == 0) ? 8'h68 : ((i == 1) ? 8'h69 : 8'h00);
        1:       mem[sel][i] = 8'(i);
        default: mem[sel][i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      endcase
    end
  endtask

  // Reference model: the expected beat list is just the first min(len,160)
  // characters of the message in order, tagged with position and label.
  task automatic append_expected(input int sel, input int len, input logic [1:0] lab);
    int eff;
    eff = model_eff(len);
    for (int k = 0; k < eff; k++)
      exp_q.push_back('{mem[sel][k], k, (k == 0), (k == eff - 1), lab});
  endtask

  task automatic present(input int sel, input int len, input logic [1:0] lab);
    for (int i = 0; i < MESSAGE_LENGTH; i++)
      bus.load_msg[CHAR_LENGTH*(MESSAGE_LENGTH-i)-1 -: CHAR_LENGTH] = mem[sel][i];
    bus.load_length = 8'(len);
    bus.load_label  = lab;
    bus.load_valid  = 1'b1;
  endtask

  // Called at a negedge with load_valid high; returns just after the
  // accepting rising edge.
  task automatic wait_accept(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (bus.load_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk({name, "_accept_timeout"}, 0, 1);
    else @(posedge clk);
  endtask

  task automatic wait_done(input string name, input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (done_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    if (!ok) chk({name, "_done_timeout"}, done_q.size(), n);
  endtask

  task automatic compare_beats(input string name);
    int n;
    chk({name, "_beat_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk({name, "_data"},  got_q[k].data,  exp_q[k].data);
      chk({name, "_index"}, got_q[k].index, exp_q[k].index);
      chk({name, "_first"}, got_q[k].first, exp_q[k].first);
      chk({name, "_last"},  got_q[k].last,  exp_q[k].last);
      chk({name, "_label"}, got_q[k].label, exp_q[k].label);
    end
  endtask

  task automatic run_msg(input int sel, input int len, input logic [1:0] lab,
                         input int rmode, input int exp_count, input string name);
    bit ok;
    exp_q.delete();
    got_q.delete();
    done_q.delete();
    append_expected(sel, len, lab);
    ready_mode = rmode;
    cyc_ready  = 0;
    @(negedge clk);
    present(sel, len, lab);
    wait_accept(name, ok);
    @(negedge clk);
    bus.load_valid = 1'b0;
    if (!ok) return;
    chk({name, "_latency_valid"}, bus.char_valid, (exp_count != 0));
    chk({name, "_latency_done"},  bus.done,       (exp_count == 0));
    wait_done(name, 1, ok);
    if (ok) begin
      @(negedge clk);
      chk({name, "_ready_after_done"}, bus.load_ready, 1);
      chk({name, "_done_one_cycle"},   bus.done,       0);
      chk({name, "_done_count"},       done_q[0],      exp_count);
    end
    chk({name, "_accepted"}, got_q.size(), exp_count);
    compare_beats(name);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin : main
    bit ok;
    int len;
    logic [1:0] lab;

    vt[0] = '{2,   LABEL_SPAM, 0, 0, 2};
    vt[1] = '{0,   LABEL_HAM,  0, 2, 0};
    vt[2] = '{200, 2'b10,      0, 1, 160};
    vt[3] = '{5,   LABEL_HAM,  1, 2, 5};
    vt[4] = '{1,   2'b11,      2, 2, 1};
    vt[5] = '{160, LABEL_SPAM, 2, 1, 160};
    vt[6] = '{161, LABEL_HAM,  0, 2, 160};
    vt[7] = '{255, LABEL_SPAM, 1, 1, 160};

    rst_n           = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_msg    = '0;
    bus.load_length = '0;
    bus.load_label  = '0;

    // Reset state
    #12;
    chk("reset_load_ready", bus.load_ready, 0);
    chk("reset_char_valid", bus.char_valid, 0);
    chk("reset_done",       bus.done,       0);
    chk("reset_busy",       bus.busy,       0);
    chk("reset_char_data",  bus.char_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_load_ready", bus.load_ready, 1);

    // Directed table
    for (int v = 0; v < 8; v++)
      begin
        fill_msg(0, vt[v].fill);
        run_msg(0, vt[v].len, vt[v].label, vt[v].ready_mode, vt[v].exp_count,
                $sformatf("vec%0d", v));
      end

    // Randomized messages against the model
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 200);
      lab = 2'($urandom_range(0, 3));
      fill_msg(0, 2);
      run_msg(0, len, lab, 2, model_eff(len), $sformatf("rand%0d", r));
    end

    // Reset in the middle of a 10-character message
    fill_msg(0, 2);
    got_q.delete();
    done_q.delete();
    ready_mode = 0;
    @(negedge clk);
    present(0, 10, LABEL_SPAM);
    wait_accept("abort", ok);
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int t = 0; t < 100 && got_q.size() < 3; t++) @(posedge clk);
    chk("abort_reached_beat3", (got_q.size() >= 3), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_char_valid", bus.char_valid, 0);
    chk("abort_busy",       bus.busy,       0);
    chk("abort_load_ready", bus.load_ready, 0);
    chk("abort_char_index", bus.char_index, 0);
    chk("abort_char_data",  bus.char_data,  0);
    chk("abort_char_label", bus.char_label, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_q.size(), 0);
    rst_n = 1'b1;
    fill_msg(1, 2);
    run_msg(1, 3, 2'b10, 0, 3, "after_abort");

    // load_valid held high across two messages
    fill_msg(0, 2);
    fill_msg(1, 2);
    exp_q.delete();
    got_q.delete();
    done_q.delete();
    append_expected(0, 4, LABEL_SPAM);
    append_expected(1, 3, LABEL_HAM);
    ready_mode = 0;
    @(negedge clk);
    present(0, 4, LABEL_SPAM);
    wait_accept("b2b_a", ok);
    @(negedge clk);
    present(1, 3, LABEL_HAM);
    chk("b2b_ready_low_while_busy", bus.load_ready, 0);
    wait_accept("b2b_b", ok);
    chk("b2b_second_load_after_done", done_q.size(), 1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    wait_done("b2b", 2, ok);
    if (ok) begin
      chk("b2b_done_count_a", done_q[0], 4);
      chk("b2b_done_count_b", done_q[1], 3);
    end
    compare_beats("b2b");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/msg_char_streamer.md
Name: msg_char_streamer

Overview:
- Transmit side of the classifier's message interface.
- Accepts one complete message in parallel: a MESSAGE_LENGTH-character buffer, a length byte and a 2-bit label.
- Emits the message one 8-bit character per cycle over a valid/ready stream, with index, first/last flags and the label.
- Feeds the character-level HDC encoder; a one-cycle done pulse marks end of message.

Parameters:
MESSAGE_LENGTH, 160, maximum characters per message
CHAR_LENGTH, 8, bits per character
LEN_WIDTH, 8, width of length and index fields

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_valid  in  1  message presented on load_*
load_ready  out  1  streamer can accept a message
load_msg  in  CHAR_LENGTH*MESSAGE_LENGTH  message buffer; char i at bits [CHAR_LENGTH*(MESSAGE_LENGTH-i)-1 -: CHAR_LENGTH] (char 0 at MSB)
load_length  in  LEN_WIDTH  number of valid characters
load_label  in  2  tag carried with the message
char_valid  out  1  char_* fields valid
char_ready  in  1  consumer accepts the character
char_data  out  CHAR_LENGTH  current character
char_index  out  LEN_WIDTH  position of char_data, 0-based
char_first  out  1  char_index==0
char_last  out  1  char_index==eff_len-1
char_label  out  2  latched load_label
done  out  1  one-cycle pulse, message finished
done_count  out  LEN_WIDTH  characters emitted, valid with done
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE. All outputs 0 except load_ready, which is 1 after reset releases. The shift register and counters are cleared.
- Reset mid-stream aborts the message immediately. No done pulse is produced and the partial message is discarded.
- Transfers happen only when valid&&ready are both high at a rising clk edge.
- eff_len = min(load_length, MESSAGE_LENGTH), computed at load. A length >160 clamps to 160.
- States: IDLE, STREAM, DONE.
- IDLE:
  - load_ready=1, char_valid=0.
  - On load_valid: capture load_msg into the shift register, eff_len and load_label.
  - If eff_len==0, go to DONE; otherwise go to STREAM with char_index=0.
- STREAM:
  - load_ready=0, char_valid=1.
  - char_data = top CHAR_LENGTH bits of the shift register. All char_* outputs are registered.
  - On a char handshake: shift left by CHAR_LENGTH and increment char_index.
  - If that handshake had char_last=1, go to DONE instead (char_valid drops next cycle).
  - While char_ready=0, all char_* outputs hold stable.
- DONE:
  - done=1 and done_count=eff_len for exactly one cycle; char_valid=0, load_ready=0.
  - Next state is IDLE.
- Latency and throughput:
  - A load accepted at edge N gives char_valid=1 with char 0 after edge N.
  - With char_ready held high, one character per cycle; a full message is eff_len cycles plus DONE.
  - The next load can be accepted no earlier than the cycle after done. Minimum turnaround is eff_len+2 cycles per message.
- Single-character message: char_first and char_last are both 1 on the same beat.
- Zero bytes (0x00) inside eff_len are emitted normally. Only length terminates the stream, not content.
- char_label holds constant for the whole message. It updates only on load.
- load_valid during STREAM/DONE is ignored (load_ready=0). Producer must hold it.

Decomposition:
- Shared package/header: MESSAGE_LENGTH, CHAR_LENGTH, LEN_WIDTH, label encodings (2'b00 ham, 2'b01 spam, others reserved), state encoding.
- One natural sub-module: msg_shift_buffer. It holds the parallel-load, left-shift-by-CHAR_LENGTH register with the top-character tap.
- The FSM, counters and handshake stay in msg_char_streamer.

Test Plan:
- Load "hi" (0x68,0x69), length=2, label=01, char_ready=1 -> beats (0x68, idx0, first), then (0x69, idx1, last), label=01 both beats; done pulse with done_count=2 on the following cycle; load_ready=1 next.
- length=0 -> no char_valid; done=1 with done_count=0 one cycle after load; back to IDLE.
- length=200, 160-char buffer -> exactly 160 beats; char_last at idx159; done_count=160.
- 5-char message with char_ready toggling 1,0,0,1,... -> char_data/char_index stable during stalls; order preserved; exactly 5 accepted beats.
- Assert reset low at beat 3 of 10 -> outputs 0 asynchronously; no done. After release, load a new 3-char message -> streams from idx0 correctly.
- load_valid held high across two messages -> second accepted only in IDLE after done; no beats dropped or duplicated.
